zap_wb_mem_bridge: RTL
======================

Name: zap_wb_mem_bridge

Overview:
Wishbone slave that terminates the merged common bus from zap_wb_merger and drives a simple req/ready memory port with a split read-data return. Sits directly downstream of the merger. Converts each Wishbone beat (classic, incrementing burst, EOB) into one memory transaction. Returns a registered single-cycle ack and read data. A read timeout prevents the core from hanging on a dead memory.

Parameters:
RD_TIMEOUT, 255, max cycles waiting for i_mem_rvalid before a forced ack (1..65535).
TIMEOUT_DATA, 32'hDEAD_DEAD, read data returned on a timed-out read.

Ports:
i_clk  in  1  clock; all logic on rising edge.
i_reset  in  1  synchronous, active-high reset.
i_wb_cyc  in  1  Wishbone cycle.
i_wb_stb  in  1  Wishbone strobe.
i_wb_wen  in  1  1 = write.
i_wb_sel  in  4  byte enables.
i_wb_dat  in  32  write data.
i_wb_adr  in  32  byte address.
i_wb_cti  in  3  cycle type: 000 classic, 010 incr, 111 EOB.
o_wb_ack  out  1  registered ack, one-cycle pulse per beat.
o_wb_dat  out  32  registered read data, valid with o_wb_ack on reads.
o_mem_req  out  1  memory request.
o_mem_wen  out  1  memory write.
o_mem_adr  out  30  word address = i_wb_adr[31:2].
o_mem_be  out  4  byte enables.
o_mem_wdata  out  32  write data.
i_mem_ready  in  1  request accepted this cycle (req & ready).
i_mem_rvalid  in  1  read data valid; in-order, one per accepted read.
i_mem_rdata  in  32  read data.
o_timeout  out  1  one-cycle pulse when a read times out.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; timeout counter 0; abort flag 0.
- FSM states: IDLE, REQ, RDWAIT, ACK, DRAIN.
- IDLE: if i_wb_cyc & i_wb_stb, latch wen/sel/dat/adr[31:2]/cti into request registers. Set o_mem_req=1 next cycle. Go to REQ.
- REQ: o_mem_req and all o_mem_* held stable until i_mem_ready.
  - Ready on a write: go to ACK.
  - Ready on a read: clear counter, go to RDWAIT.
- RDWAIT: counter increments each cycle.
  - i_mem_rvalid: register i_mem_rdata into o_wb_dat, go to ACK.
  - Counter reaches RD_TIMEOUT with no rvalid: o_wb_dat = TIMEOUT_DATA, pulse o_timeout, go to DRAIN.
- DRAIN: wait for the late rvalid and discard its data; this keeps the memory in order. Raise o_wb_ack for one cycle on entry, then stay in DRAIN until rvalid, then go to IDLE. A new request is not accepted while in DRAIN.
- ACK: o_wb_ack = 1 for exactly this cycle. stb/adr on the bus are ignored here, because the bus still shows the old request (merger output is registered). Next state is IDLE.
- Latency (memory ready at once):
  - Write: stb seen in cycle t gives ack in cycle t+2.
  - Read with rvalid at t+k: ack at t+k+1.
  - Minimum beat spacing is 3 cycles; throughput on bursts equals that on classic cycles.
- Burst: CTI is only latched. Each beat is an independent memory transaction and incr bursts need no special path. The address is taken from the bus on every beat; no internal increment.
- i_wb_cyc drops in REQ or RDWAIT (abort): the memory transaction completes, because a req cannot be withdrawn and rvalid must be consumed. Set abort=1, suppress o_wb_ack and o_wb_dat update, return to IDLE. Abort is cleared in IDLE.
- i_wb_cyc & !i_wb_stb in IDLE: no action.
- Simultaneous rvalid and timeout in the same cycle: rvalid wins (normal ack, no o_timeout).
- i_mem_rvalid outside RDWAIT/DRAIN: protocol error; ignored (assertion in sim).
- Reset mid-operation: the FSM returns to IDLE immediately, and o_mem_req drops even if not accepted. The memory side must be reset together with the bridge.
- Counter width is clog2(RD_TIMEOUT+1); it saturates, never wraps.

Decomposition:
- Shared package zap_wb_pkg holds:
  - CTI_CLASSIC, CTI_INCR, CTI_EOB constants (also used by the merger and caches).
  - Bridge state enum typedef.
  - TIMEOUT_DATA default.
- No sub-module is needed. The timeout counter is inline.

Test Plan:
1. Classic write adr=0x0000_1004, sel=4'b0011, dat=0xA5A5_1234, ready at once -> o_mem_adr=0x401, be=0011 held 1 cycle; o_wb_ack 2 cycles after stb; exactly one ack.
2. Classic read adr=0x100, ready after 3 cycles, rvalid 2 cycles later with 0xCAFEF00D -> req held stable 3 cycles; ack with o_wb_dat=0xCAFEF00D one cycle after rvalid.
3. 4-beat incr burst read from 0x200 (cti 010,010,010,111), rdata = adr -> 4 memory reqs at word addresses 0x80..0x83; 4 acks with matching data; no duplicate request from the stale stb during ACK.
4. Read, rvalid never arrives, RD_TIMEOUT=8 -> o_timeout and ack with 0xDEADDEAD at cycle 8 of RDWAIT; a new stb is not serviced until the late rvalid is drained.
5. Read accepted, cyc drops during RDWAIT, rvalid 5 cycles later -> no ack, o_wb_dat unchanged, FSM back in IDLE; the next write is acked normally.
6. Reset asserted in REQ with ready low -> o_mem_req=0, o_wb_ack=0 and FSM in IDLE on the next cycle.

Source files
------------

// File: rtl/zap_wb_pkg.sv
// Shared Wishbone definitions for the ZAP bus fabric: cycle-type codes,
// memory bridge state encoding and the default poison word for dead reads.
package zap_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_DEAD;

    typedef enum logic [2:0] {
        BR_IDLE   = 3'd0,
        BR_REQ    = 3'd1,
        BR_RDWAIT = 3'd2,
        BR_ACK    = 3'd3,
        BR_DRAIN  = 3'd4
    } bridge_state_t;

endpackage

// File: rtl/zap_wb_mem_bridge_chk.sv
// Simulation-only protocol checks for the Wishbone-to-memory bridge.
module zap_wb_mem_bridge_chk
    import zap_wb_pkg::*;
(
    input logic          i_clk,
    input logic          i_reset,
    input bridge_state_t state,
    input logic          mem_rvalid,
    input logic [2:0]    cti
);

    // Read data may only come back while a read is outstanding.
    a_rvalid_in_window: assert property (@(posedge i_clk) disable iff (i_reset)
        mem_rvalid |-> (state == BR_RDWAIT || state == BR_DRAIN));

    // The latched cycle type must be one the fabric actually generates.
    a_cti_legal: assert property (@(posedge i_clk) disable iff (i_reset)
        (state == BR_REQ) |-> (cti == CTI_CLASSIC || cti == CTI_INCR || cti == CTI_EOB));

endmodule

// File: rtl/zap_wb_mem_bridge.sv
// Terminates the merged ZAP Wishbone bus: one memory transaction per beat,
// registered ack/read data, and a read timeout that drains the late response.
module zap_wb_mem_bridge
    import zap_wb_pkg::*;
#(
    parameter int          RD_TIMEOUT   = 255,
    parameter logic [31:0] TIMEOUT_DATA = TIMEOUT_DATA_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_wen,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_dat,
    input  logic [31:0] i_wb_adr,
    input  logic [2:0]  i_wb_cti,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_dat,
    output logic        o_mem_req,
    output logic        o_mem_wen,
    output logic [29:0] o_mem_adr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_timeout
);

    localparam int               CNT_W    = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    bridge_state_t    state_r, state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             abort_r;
    logic             req_r, wen_r, ack_r, to_r;
    logic [3:0]       sel_r;
    logic [31:0]      wdat_r, rdat_r;
    logic [29:0]      adr_r;
    logic [2:0]       cti_r;

    logic accept_s, req_clr_s, cnt_clr_s, ack_set_s;
    logic dat_load_s, dat_to_s, to_set_s, abort_set_s, abort_now_s;
    logic unused_adr_s;

    assign unused_adr_s = ^i_wb_adr[1:0];

    // Next-state and per-cycle control decode.
    always_comb begin
        state_s     = state_r;
        accept_s    = 1'b0;
        req_clr_s   = 1'b0;
        cnt_clr_s   = 1'b0;
        ack_set_s   = 1'b0;
        dat_load_s  = 1'b0;
        dat_to_s    = 1'b0;
        to_set_s    = 1'b0;
        abort_set_s = 1'b0;
        abort_now_s = abort_r | ~i_wb_cyc;
        case (state_r)
            BR_IDLE: begin
                if (i_wb_cyc && i_wb_stb) begin
                    accept_s = 1'b1;
                    state_s  = BR_REQ;
                end else begin
                    state_s = BR_IDLE;
                end
            end
            BR_REQ: begin
                abort_set_s = ~i_wb_cyc;
                if (i_mem_ready) begin
                    req_clr_s = 1'b1;
                    if (wen_r) begin
                        ack_set_s = ~abort_now_s;
                        state_s   = abort_now_s ? BR_IDLE : BR_ACK;
                    end else begin
                        cnt_clr_s = 1'b1;
                        state_s   = BR_RDWAIT;
                    end
                end else begin
                    state_s = BR_REQ;
                end
            end
            BR_RDWAIT: begin
                abort_set_s = ~i_wb_cyc;
                // A response in the final wait cycle beats the timeout.
                if (i_mem_rvalid) begin
                    ack_set_s  = ~abort_now_s;
                    dat_load_s = ~abort_now_s;
                    state_s    = abort_now_s ? BR_IDLE : BR_ACK;
                end else if (cnt_r >= CNT_LAST) begin
                    to_set_s  = 1'b1;
                    ack_set_s = ~abort_now_s;
                    dat_to_s  = ~abort_now_s;
                    state_s   = BR_DRAIN;
                end else begin
                    state_s = BR_RDWAIT;
                end
            end
            BR_ACK: begin
                state_s = BR_IDLE;
            end
            BR_DRAIN: begin
                if (i_mem_rvalid) begin
                    state_s = BR_IDLE;
                end else begin
                    state_s = BR_DRAIN;
                end
            end
            default: begin
                state_s = BR_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) state_r <= BR_IDLE;
        else         state_r <= state_s;
    end

    // Request registers: captured once per beat and held until accepted.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            req_r  <= 1'b0;
            wen_r  <= 1'b0;
            sel_r  <= 4'b0000;
            wdat_r <= 32'h0000_0000;
            adr_r  <= 30'h0000_0000;
            cti_r  <= 3'b000;
        end else if (accept_s) begin
            req_r  <= 1'b1;
            wen_r  <= i_wb_wen;
            sel_r  <= i_wb_sel;
            wdat_r <= i_wb_dat;
            adr_r  <= i_wb_adr[31:2];
            cti_r  <= i_wb_cti;
        end else if (req_clr_s) begin
            req_r <= 1'b0;
        end
    end

    // Read-wait counter, saturating at RD_TIMEOUT.
    always_ff @(posedge i_clk) begin
        if (i_reset)                                     cnt_r <= '0;
        else if (cnt_clr_s)                              cnt_r <= '0;
        else if (state_r == BR_RDWAIT && cnt_r != CNT_MAX) cnt_r <= cnt_r + CNT_ONE;
        else                                             cnt_r <= cnt_r;
    end

    // Abort flag: remembers that the master left while memory was busy.
    always_ff @(posedge i_clk) begin
        if (i_reset)                 abort_r <= 1'b0;
        else if (state_r == BR_IDLE) abort_r <= 1'b0;
        else if (abort_set_s)        abort_r <= 1'b1;
    end

    // Wishbone response registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ack_r  <= 1'b0;
            to_r   <= 1'b0;
            rdat_r <= 32'h0000_0000;
        end else begin
            ack_r <= ack_set_s;
            to_r  <= to_set_s;
            if (dat_load_s)    rdat_r <= i_mem_rdata;
            else if (dat_to_s) rdat_r <= TIMEOUT_DATA;
        end
    end

    assign o_wb_ack    = ack_r;
    assign o_wb_dat    = rdat_r;
    assign o_timeout   = to_r;
    assign o_mem_req   = req_r;
    assign o_mem_wen   = wen_r;
    assign o_mem_adr   = adr_r;
    assign o_mem_be    = sel_r;
    assign o_mem_wdata = wdat_r;

    zap_wb_mem_bridge_chk u_chk (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .state      (state_r),
        .mem_rvalid (i_mem_rvalid),
        .cti        (cti_r)
    );

endmodule
